player_sequencer: RTL and testbench
===================================

# player_sequencer

Playback sequencer in the `r_clk` domain that drives the `reset_n` input of one or more `player` instances. It plays the first `cfg_length` samples of the buffer, inserts a configurable gap, and repeats for `cfg_repeats` passes (0 = forever). It emits a valid/index strobe aligned with each player `r_out` sample, so downstream logic knows which sample and which pass is on the bus. It replaces the direct enable-to-reset connection between the synchronizer and the player bank.

## Interface
- `timeBits`, 10: player address width; buffer depth is 2^timeBits.
- `countBits`, 16: width of the repeat counter, the gap counter and the pass index.
- `r_clk` input 1: playback clock, the same clock as the players' `r_clk`.
- `r_reset_n` input 1: block reset, synchronous, active-low; clock `r_clk`.
- `start` input 1: begin a sequence; sampled only in IDLE.
- `stop` input 1: abort; has priority over `start`.
- `cfg_length` input timeBits+1: samples per pass; legal range 1..2^timeBits.
- `cfg_repeats` input countBits: number of passes; 0 = infinite.
- `cfg_gap` input countBits: extra idle cycles between passes.
- `player_reset_n` output 1: drives `player.r_reset_n`.
- `out_valid` output 1: the player's `r_out` holds a sequenced sample this cycle.
- `out_index` output timeBits: buffer address of the sample currently on `r_out`.
- `out_pass` output countBits: pass number of the sample currently on `r_out`, starting at 0.
- `busy` output 1: high when the state is not IDLE.
- `done` output 1: one-cycle pulse on natural completion.

## Operation
- State machine with three states: IDLE, PLAY, GAP.
- `player_reset_n` is 1 exactly when state = PLAY; it is decoded from the state register only.
- `busy` is 1 when state ≠ IDLE.
- **Start.** In IDLE with `start`=1, `stop`=0 and `cfg_length`≠0:
  - latch `cfg_length`, `cfg_repeats` and `cfg_gap`;
  - clear `sample_cnt` and `pass_cnt`;
  - go to PLAY.
- `start` with `cfg_length`=0 is ignored. A `cfg_length` above 2^timeBits is clamped to 2^timeBits at latch.
- Configuration changes after the latch have no effect until the next start.
- `start` is ignored outside IDLE.
- **PLAY.** Increment `sample_cnt` each cycle.
  - When `sample_cnt` = len−1, clear `sample_cnt`, then:
    - if `cfg_repeats`≠0 and `pass_cnt`+1 = `cfg_repeats`: go to IDLE and pulse `done`;
    - otherwise: increment `pass_cnt` (wrapping modulo 2^countBits when repeats = 0), load `gap_cnt` = `cfg_gap`, and go to GAP.
- **GAP.** `player_reset_n`=0, which returns the player address to 0.
  - If `gap_cnt`=0, go to PLAY; otherwise decrement `gap_cnt`.
  - GAP therefore always lasts `cfg_gap`+1 cycles, with a minimum of 1 cycle. That one cycle is required to re-zero the player address.
- **Stop.** `stop`=1 in any state moves to IDLE at the next edge and does not pulse `done`. Samples already in the player output register still produce their `out_valid` cycle.
- **Output alignment.** Registered every edge:
  - `out_valid` <= (state = PLAY);
  - `out_index` <= `sample_cnt`;
  - `out_pass` <= `pass_cnt`.
- `done` is registered. It goes high in the same cycle as the `out_valid` of the final sample.

## Timing
- Reset: when `r_reset_n`=0 at an edge, all of the following hold after that edge, overriding everything:
  - state = IDLE;
  - `player_reset_n`, `out_valid`, `busy` and `done` are 0;
  - `out_index` and `out_pass` are 0;
  - all counters are 0.
- Reset in the middle of a run behaves the same: `out_valid` is 0 from the cycle after the reset edge.
- Start latency: `start` is sampled at edge E0. `player_reset_n` and `busy` are 1 after E0. `out_valid` is 1 with `r_out` = mem[0] and `out_index`=0 after E1.
- Each pass gives exactly len consecutive `out_valid` cycles, with `out_index` 0..len−1.
- Between passes, `out_valid` is low for exactly `cfg_gap`+1 cycles.
- `done` is high for 1 cycle, aligned with `out_index`=len−1 of the last pass. `busy` is already 0 in that cycle.
- A new `start` is accepted at the edge where `done` is high. Back-to-back sequences have a 1-cycle `out_valid` gap.
- With len = 2^timeBits, the player reaches its own done state exactly as PLAY exits. No behaviour differs.
- When `start` and `stop` are asserted together in IDLE, the block stays in IDLE.

## Test plan
- **Basic pass.** Length=4, repeats=1, gap=0, mem[i]=i+100, pulse `start`.
  - Response: `out_valid` for 4 cycles with `r_out` 100..103 and `out_index` 0..3.
  - `done` coincides with `out_index`=3.
  - `player_reset_n` is high for exactly 4 cycles.
- **Repeats with gap.** Length=3, repeats=3, gap=2.
  - Response: three bursts of 3 valids, `out_pass` 0,1,2, separated by exactly 3 low cycles.
  - A single `done` after the 9th valid.
- **Infinite and stop.** Length=2, repeats=0, gap=0.
  - Response: alternating 2 valid / 1 idle, with `out_pass` incrementing.
  - Assert `stop` mid-pass: `busy` drops at the next edge, at most 1 trailing valid, no `done`.
- **Edge lengths.**
  - `cfg_length`=0 with `start`: `busy` stays 0.
  - `cfg_length`=2^timeBits+5: the run produces exactly 1024 valids with `out_index` 0..1023 (timeBits=10).
- **Reset and config stability.**
  - Assert `r_reset_n`=0 mid-run: all outputs are 0 after the edge.
  - Change `cfg_length` mid-run: the current run keeps its latched length.
  - `start` at the `done` edge: a new run begins with a 1-cycle gap.

Source files
------------

// File: rtl/player_sequencer.sv
// Playback sequencer: drives the player bank reset, repeats the first cfg_length
// samples for cfg_repeats passes with a gap, and tags each output sample.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; player held in reset
// PLAY  | player running; one buffer sample per cycle
// GAP   | player held in reset between passes (cfg_gap+1 cycles)
module player_sequencer #(
    parameter int timeBits  = 10,
    parameter int countBits = 16
) (
    input  logic                 r_clk,
    input  logic                 r_reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [timeBits:0]    cfg_length,
    input  logic [countBits-1:0] cfg_repeats,
    input  logic [countBits-1:0] cfg_gap,
    output logic                 player_reset_n,
    output logic                 out_valid,
    output logic [timeBits-1:0]  out_index,
    output logic [countBits-1:0] out_pass,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [timeBits:0]    max_len   = {1'b1, {timeBits{1'b0}}};
    localparam logic [timeBits:0]    len_one   = {{timeBits{1'b0}}, 1'b1};
    localparam logic [countBits-1:0] count_one = {{(countBits-1){1'b0}}, 1'b1};
    localparam logic [timeBits-1:0]  index_one = {{(timeBits-1){1'b0}}, 1'b1};

    state_t                 state, state_nxt;
    logic [timeBits:0]      len_q, len_nxt;
    logic [countBits-1:0]   repeats_q, repeats_nxt;
    logic [countBits-1:0]   gap_q, gap_nxt;
    logic [timeBits-1:0]    sample_cnt, sample_cnt_nxt;
    logic [countBits-1:0]   pass_cnt, pass_cnt_nxt;
    logic [countBits-1:0]   gap_cnt, gap_cnt_nxt;
    logic                   done_nxt;

    logic [timeBits:0]      cfg_len_clamped;
    logic [timeBits:0]      len_m1;
    logic [countBits-1:0]   pass_cnt_inc;
    logic                   last_sample;
    logic                   last_pass;

    assign cfg_len_clamped = (cfg_length > max_len) ? max_len : cfg_length;
    assign len_m1          = len_q - len_one;
    assign pass_cnt_inc    = pass_cnt + count_one;
    assign last_sample     = ({1'b0, sample_cnt} == len_m1);
    assign last_pass       = (repeats_q != '0) && (pass_cnt_inc == repeats_q);

    always_comb begin
        state_nxt      = state;
        len_nxt        = len_q;
        repeats_nxt    = repeats_q;
        gap_nxt        = gap_q;
        sample_cnt_nxt = sample_cnt;
        pass_cnt_nxt   = pass_cnt;
        gap_cnt_nxt    = gap_cnt;
        done_nxt       = 1'b0;

        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (cfg_length != '0)) begin
                        len_nxt        = cfg_len_clamped;
                        repeats_nxt    = cfg_repeats;
                        gap_nxt        = cfg_gap;
                        sample_cnt_nxt = '0;
                        pass_cnt_nxt   = '0;
                        state_nxt      = PLAY;
                    end
                end
                PLAY: begin
                    if (last_sample) begin
                        sample_cnt_nxt = '0;
                        if (last_pass) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            // repeats = 0 lets the pass counter wrap freely
                            pass_cnt_nxt = pass_cnt_inc;
                            gap_cnt_nxt  = gap_q;
                            state_nxt    = GAP;
                        end
                    end else begin
                        sample_cnt_nxt = sample_cnt + index_one;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state_nxt = PLAY;
                    end else begin
                        gap_cnt_nxt = gap_cnt - count_one;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            state      <= IDLE;
            len_q      <= '0;
            repeats_q  <= '0;
            gap_q      <= '0;
            sample_cnt <= '0;
            pass_cnt   <= '0;
            gap_cnt    <= '0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_pass   <= '0;
        end else begin
            state      <= state_nxt;
            len_q      <= len_nxt;
            repeats_q  <= repeats_nxt;
            gap_q      <= gap_nxt;
            sample_cnt <= sample_cnt_nxt;
            pass_cnt   <= pass_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            done       <= done_nxt;
            // tags line up with the player's registered r_out one cycle later
            out_valid  <= (state == PLAY);
            out_index  <= sample_cnt;
            out_pass   <= pass_cnt;
        end
    end

    assign player_reset_n = (state == PLAY);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_player_sequencer.sv
// Randomized bench for player_sequencer; expected outputs come from a per-cycle
// playback timeline built from the configuration (passes, samples, gaps).
module tb_player_sequencer;

    logic        r_clk = 1'b0;
    logic        r_reset_n;
    logic        start;
    logic        stop;
    logic [10:0] cfg_length;
    logic [15:0] cfg_repeats;
    logic [15:0] cfg_gap;
    logic        player_reset_n;
    logic        out_valid;
    logic [9:0]  out_index;
    logic [15:0] out_pass;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit play;
        int idx;
        int pass;
    } ent_t;

    ent_t tl[$];

    player_sequencer #(.timeBits(10), .countBits(16)) dut (
        .r_clk          (r_clk),
        .r_reset_n      (r_reset_n),
        .start          (start),
        .stop           (stop),
        .cfg_length     (cfg_length),
        .cfg_repeats    (cfg_repeats),
        .cfg_gap        (cfg_gap),
        .player_reset_n (player_reset_n),
        .out_valid      (out_valid),
        .out_index      (out_index),
        .out_pass       (out_pass),
        .busy           (busy),
        .done           (done)
    );

    always #5 r_clk = ~r_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic check_idle(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            check_eq("idle_valid", int'(out_valid), 0);
            check_eq("idle_busy", int'(busy), 0);
            check_eq("idle_done", int'(done), 0);
            check_eq("idle_prst", int'(player_reset_n), 0);
        end
    endtask

    // stop_at > 0 asserts stop so it is sampled at edge stop_at after the start edge
    task automatic run_seq(input int len_cfg, input int rep, input int gap, input int stop_at);
        int   eff_len;
        int   t_len;
        bit   natural;
        ent_t prev;
        eff_len = (len_cfg > 1024) ? 1024 : len_cfg;
        tl.delete();
        for (int p = 0; ; p++) begin
            for (int i = 0; i < eff_len; i++) tl.push_back('{1'b1, i, p});
            if (rep != 0 && p == rep - 1) break;
            if (rep == 0 && tl.size() > stop_at) break;
            for (int g = 0; g <= gap; g++) tl.push_back('{1'b0, 0, 0});
        end
        t_len   = tl.size();
        natural = 1'b1;
        if (stop_at > 0 && stop_at < t_len) begin
            t_len   = stop_at;
            natural = 1'b0;
        end

        cfg_length  = 11'(len_cfg);
        cfg_repeats = 16'(rep);
        cfg_gap     = 16'(gap);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        // scramble the config; the running sequence must ignore it
        cfg_length  = 11'($urandom_range(0, 2047));
        cfg_repeats = 16'($urandom_range(0, 65535));
        cfg_gap     = 16'($urandom_range(0, 65535));

        for (int k = 0; k <= t_len; k++) begin
            if (k > 0) begin
                if (!natural && k == t_len) stop = 1'b1;
                start = ($urandom_range(0, 5) == 0);
                tick();
                stop  = 1'b0;
                start = 1'b0;
            end
            prev = (k >= 1) ? tl[k-1] : '{1'b0, 0, 0};
            check_eq("busy", int'(busy), (k < t_len) ? 1 : 0);
            check_eq("prst", int'(player_reset_n), (k < t_len && tl[k].play) ? 1 : 0);
            check_eq("valid", int'(out_valid), int'(prev.play));
            if (prev.play) begin
                check_eq("index", int'(out_index), prev.idx);
                check_eq("pass", int'(out_pass), prev.pass);
            end
            check_eq("done", int'(done), (natural && k == t_len) ? 1 : 0);
        end
    endtask

    initial begin
        int len_r, rep_r, gap_r, stop_r;
        r_reset_n   = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        cfg_length  = '0;
        cfg_repeats = '0;
        cfg_gap     = '0;
        tick();
        tick();
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_prst", int'(player_reset_n), 0);
        check_eq("rst_index", int'(out_index), 0);
        check_eq("rst_pass", int'(out_pass), 0);
        r_reset_n = 1'b1;
        check_idle(2);

        run_seq(4, 1, 0, 0);
        check_idle(2);
        run_seq(3, 3, 2, 0);
        check_idle(2);
        run_seq(2, 0, 0, 7);
        check_idle(2);

        // zero length start is ignored
        cfg_length = '0;
        cfg_repeats = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("len0_busy", int'(busy), 0);
        check_idle(2);

        // stop wins over start in IDLE
        cfg_length = 11'd5;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_eq("startstop_busy", int'(busy), 0);
        check_idle(2);

        run_seq(1029, 1, 0, 0);
        check_idle(1);

        // back-to-back: second start sampled at the edge closing the done cycle
        run_seq(3, 2, 1, 0);
        run_seq(2, 1, 0, 0);
        check_idle(2);

        // reset in the middle of a run
        cfg_length  = 11'd10;
        cfg_repeats = 16'd0;
        cfg_gap     = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        r_reset_n = 1'b0;
        tick();
        check_eq("mrst_valid", int'(out_valid), 0);
        check_eq("mrst_busy", int'(busy), 0);
        check_eq("mrst_done", int'(done), 0);
        check_eq("mrst_prst", int'(player_reset_n), 0);
        check_eq("mrst_index", int'(out_index), 0);
        check_eq("mrst_pass", int'(out_pass), 0);
        r_reset_n = 1'b1;
        check_idle(2);

        for (int it = 0; it < 25; it++) begin
            len_r = $urandom_range(1, 24);
            rep_r = $urandom_range(0, 4);
            gap_r = $urandom_range(0, 4);
            if (rep_r == 0) stop_r = $urandom_range(1, 40);
            else stop_r = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
            run_seq(len_r, rep_r, gap_r, stop_r);
            if ($urandom_range(0, 1) == 1) check_idle(1);
        end
        check_idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
